// File: rtl/lane_merge_serializer.sv
// lane_merge_serializer
// Captures a set of NUM_LANES parallel lane words and emits them one per
// cycle in ascending lane order over a valid/ready output port. The last
// lane of a set can overlap with the accept of the next set, so a continuous
// producer sees no bubble. Optionally skips lanes whose valid bit is clear.
module lane_merge_serializer #(
  parameter int NUM_LANES    = 4,
  parameter int DATA_W       = 8,
  parameter int SKIP_INVALID = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  input  logic [NUM_LANES-1:0]          in_lane_valid,
  input  logic                          in_load,
  output logic                          in_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_vbit,
  output logic [$clog2(NUM_LANES)-1:0]  out_lane,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(NUM_LANES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Registered state
  state_t                         state_q, state_d;
  logic [NUM_LANES-1:0]           mask_q, mask_d;
  logic [NUM_LANES*DATA_W-1:0]    data_q, data_d;
  logic [NUM_LANES-1:0]           vbit_q, vbit_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic                           ovf_q;

  // Combinational helpers
  logic [NUM_LANES-1:0]           ptr_onehot;
  logic [NUM_LANES-1:0]           rest_mask;
  logic [NUM_LANES-1:0]           new_mask;
  logic                           is_last;
  logic                           accept;

  // Index of the lowest set bit; zero for an empty mask.
  function automatic logic [PTR_W-1:0] lowest_lane(input logic [NUM_LANES-1:0] m);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

  // Pending lanes left after the current pointer lane is emitted. Bits below
  // the pointer are already clear, so the remaining lowest bit is the next lane.
  assign ptr_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << ptr_q;
  assign rest_mask  = mask_q & ~ptr_onehot;
  assign is_last    = (rest_mask == '0);

  // With skipping disabled every lane is emitted, carrying its valid bit.
  assign new_mask = (SKIP_INVALID != 0) ? in_lane_valid : {NUM_LANES{1'b1}};

  // The only input-to-output combinational path: the last word being consumed
  // frees the holding registers for a new set in the same cycle.
  assign in_ready = (state_q == IDLE) || (is_last && out_ready);
  assign accept   = in_load && in_ready;

  // Outputs are selected purely from registered state.
  assign out_valid = (state_q == SEND);
  assign out_data  = data_q[ptr_q*DATA_W +: DATA_W];
  assign out_vbit  = vbit_q[ptr_q];
  assign out_lane  = ptr_q;
  assign overflow  = ovf_q;

  // Next-state logic: capture a new set on accept, otherwise step through lanes.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    vbit_d  = vbit_q;
    ptr_d   = ptr_q;

    if (accept) begin
      // In SEND an accept implies the last word is being consumed right now.
      data_d  = in_data;
      vbit_d  = in_lane_valid;
      mask_d  = new_mask;
      ptr_d   = lowest_lane(new_mask);
      state_d = (new_mask != '0) ? SEND : IDLE;
    end else if (state_q == SEND && out_ready) begin
      if (is_last) begin
        mask_d  = '0;
        ptr_d   = '0;
        state_d = IDLE;
      end else begin
        mask_d  = rest_mask;
        ptr_d   = lowest_lane(rest_mask);
      end
    end
  end

  // State register for the FSM, mask, pointer and holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the held lane data is cleared on reset so out_data reads zero
      // while idle; it is a handful of flops, not a RAM, so this is cheap.
      state_q <= IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      vbit_q  <= '0;
      ptr_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      vbit_q  <= vbit_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sticky overflow: an offer made while not ready is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (in_load && !in_ready) begin
      ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_merge_serializer.sv
// Self-checking bench for lane_merge_serializer. Three instances cover
// 4/8/skip, 4/8/no-skip and 8/16/skip. A per-instance scoreboard queue holds
// the lane words still owed; the monitor compares the head every output cycle.
module tb_lane_merge_serializer;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  l;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  // Instance a: 4 lanes, 8 bits, skip invalid
  logic [31:0] a_din;
  logic [3:0]  a_vin;
  logic        a_ld, a_ordy, a_rdy, a_ovf, a_oval, a_ovb;
  logic [7:0]  a_od;
  logic [1:0]  a_ol;

  // Instance b: 4 lanes, 8 bits, emit all lanes
  logic [31:0] b_din;
  logic [3:0]  b_vin;
  logic        b_ld, b_ordy, b_rdy, b_ovf, b_oval, b_ovb;
  logic [7:0]  b_od;
  logic [1:0]  b_ol;

  // Instance c: 8 lanes, 16 bits, skip invalid
  logic [127:0] c_din;
  logic [7:0]   c_vin;
  logic         c_ld, c_ordy, c_rdy, c_ovf, c_oval, c_ovb;
  logic [15:0]  c_od;
  logic [2:0]   c_ol;

  exp_t sbq [3][$];
  bit   exp_ovf [3];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lane_merge_serializer #(.NUM_LANES(4), .DATA_W(8), .SKIP_INVALID(1)) u_a (
    .clk(clk), .reset(rst), .in_data(a_din), .in_lane_valid(a_vin),
    .in_load(a_ld), .in_ready(a_rdy), .out_data(a_od), .out_vbit(a_ovb),
    .out_lane(a_ol), .out_valid(a_oval), .out_ready(a_ordy), .overflow(a_ovf)
  );

  lane_merge_serializer #(.NUM_LANES(4), .DATA_W(8), .SKIP_INVALID(0)) u_b (
    .clk(clk), .reset(rst), .in_data(b_din), .in_lane_valid(b_vin),
    .in_load(b_ld), .in_ready(b_rdy), .out_data(b_od), .out_vbit(b_ovb),
    .out_lane(b_ol), .out_valid(b_oval), .out_ready(b_ordy), .overflow(b_ovf)
  );

  lane_merge_serializer #(.NUM_LANES(8), .DATA_W(16), .SKIP_INVALID(1)) u_c (
    .clk(clk), .reset(rst), .in_data(c_din), .in_lane_valid(c_vin),
    .in_load(c_ld), .in_ready(c_rdy), .out_data(c_od), .out_vbit(c_ovb),
    .out_lane(c_ol), .out_valid(c_oval), .out_ready(c_ordy), .overflow(c_ovf)
  );

  task automatic check(input string tag, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @%0t: got 0x%0h expected 0x%0h", tag, d, $time, act, exp);
    end
  endtask

  // One monitor step per instance, run on the falling edge. Checks handshake
  // and output against the model, then updates the model for the next edge.
  task automatic mon_step(input int d, input int nl, input int dw, input bit skip,
                          input logic ld, input logic [127:0] din, input logic [7:0] vin,
                          input logic ordy, input logic rdy, input logic ovf,
                          input logic oval, input logic [15:0] od,
                          input logic [3:0] ol, input logic ovb);
    exp_t         e;
    logic         exp_rdy;
    logic [127:0] sh;
    if (rst) begin
      sbq[d].delete();
      exp_ovf[d] = 1'b0;
      check("rst_in_ready", d, 32'(rdy), 32'd1);
      check("rst_out_valid", d, 32'(oval), 32'd0);
      check("rst_overflow", d, 32'(ovf), 32'd0);
      check("rst_out_data", d, 32'(od), 32'd0);
      check("rst_out_lane", d, 32'(ol), 32'd0);
      return;
    end
    exp_rdy = (sbq[d].size() == 0) || (sbq[d].size() == 1 && ordy);
    check("in_ready", d, 32'(rdy), 32'(exp_rdy));
    check("out_valid", d, 32'(oval), 32'(sbq[d].size() != 0));
    check("overflow", d, 32'(ovf), 32'(exp_ovf[d]));
    if (oval && sbq[d].size() != 0) begin
      e = sbq[d][0];
      check("out_data", d, 32'(od), 32'(e.d));
      check("out_lane", d, 32'(ol), 32'(e.l));
      check("out_vbit", d, 32'(ovb), 32'(e.v));
      if (ordy) void'(sbq[d].pop_front());
    end
    if (ld) begin
      if (exp_rdy) begin
        for (int i = 0; i < nl; i++) begin
          if (!skip || vin[i]) begin
            sh  = din >> (i * dw);
            e.d = (dw == 8) ? {8'h00, sh[7:0]} : sh[15:0];
            e.l = 4'(i);
            e.v = vin[i];
            sbq[d].push_back(e);
          end
        end
      end else begin
        exp_ovf[d] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, 4, 8, 1'b1, a_ld, {96'h0, a_din}, {4'h0, a_vin}, a_ordy, a_rdy,
             a_ovf, a_oval, {8'h00, a_od}, {2'b00, a_ol}, a_ovb);
    mon_step(1, 4, 8, 1'b0, b_ld, {96'h0, b_din}, {4'h0, b_vin}, b_ordy, b_rdy,
             b_ovf, b_oval, {8'h00, b_od}, {2'b00, b_ol}, b_ovb);
    mon_step(2, 8, 16, 1'b1, c_ld, c_din, c_vin, c_ordy, c_rdy,
             c_ovf, c_oval, c_od, {1'b0, c_ol}, c_ovb);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_ld = 1'b0; a_din = '0; a_vin = '0; a_ordy = 1'b1;
    b_ld = 1'b0; b_din = '0; b_vin = '0; b_ordy = 1'b1;
    c_ld = 1'b0; c_din = '0; c_vin = '0; c_ordy = 1'b1;
    step(3);
    rst = 1'b0;

    // Full set, first accept right after reset release
    a_ld = 1'b1; a_din = 32'h4433_2211; a_vin = 4'b1111;
    step(1);
    a_ld = 1'b0;
    step(6);

    // Sparse mask, then an all-zero mask that must produce nothing
    a_ld = 1'b1; a_din = 32'hBB00_AA00; a_vin = 4'b1010;
    step(1);
    a_ld = 1'b0;
    step(4);
    a_ld = 1'b1; a_vin = 4'b0000;
    step(1);
    a_ld = 1'b0;
    step(3);

    // No-skip instance: every lane emitted with its valid bit
    b_ld = 1'b1; b_din = 32'h4433_2211; b_vin = 4'b0101;
    step(1);
    b_ld = 1'b0;
    step(6);

    // Back-pressure on lane 2 for three cycles
    a_ld = 1'b1; a_din = 32'h8877_6655; a_vin = 4'b1111;
    step(1);
    a_ld = 1'b0;
    step(2);
    a_ordy = 1'b0;
    step(3);
    a_ordy = 1'b1;
    step(4);

    // in_load held high: back-to-back sets, extra offers set overflow
    a_ld = 1'b1;
    for (int k = 0; k < 14; k++) begin
      a_din = $urandom;
      a_vin = 4'($urandom_range(1, 15));
      step(1);
    end
    a_ld = 1'b0;
    step(6);

    // Reset in the middle of lane 2 aborts the set
    a_ld = 1'b1; a_din = 32'hDDCC_BBAA; a_vin = 4'b1111;
    step(1);
    a_ld = 1'b0;
    step(2);
    #1 rst = 1'b1;
    #1;
    check("rst_imm_out_valid", 0, 32'(a_oval), 32'd0);
    check("rst_imm_overflow", 0, 32'(a_ovf), 32'd0);
    step(2);
    rst = 1'b0;
    a_ld = 1'b1; a_din = 32'h4433_2211; a_vin = 4'b1100;
    step(1);
    a_ld = 1'b0;
    step(5);

    // Wide instance: random masks, random data, random sink stalls
    for (int k = 0; k < 400; k++) begin
      c_ld   = 1'($urandom_range(0, 1));
      c_din  = {$urandom, $urandom, $urandom, $urandom};
      c_vin  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      c_ordy = ($urandom_range(0, 3) != 0);
      step(1);
    end
    c_ld = 1'b0; c_ordy = 1'b1;
    step(12);
    check("drain_c", 2, 32'(sbq[2].size()), 32'd0);
    check("drain_a", 0, 32'(sbq[0].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_merge_serializer.md
LANE_MERGE_SERIALIZER -- requirements
Module: lane_merge_serializer

Interface
REQ-001 Parameter NUM_LANES, default 4, number of parallel input lanes (legal range 2..16).
REQ-002 Parameter DATA_W, default 8, data bits per lane, excluding the valid bit.
REQ-003 Parameter SKIP_INVALID, default 1: 1 = emit only lanes whose valid bit is set; 0 = emit every lane together with its valid bit.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high; clears all state immediately.
REQ-006 Port in_data, input, NUM_LANES*DATA_W bits: lane i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port in_lane_valid, input, NUM_LANES bits: per-lane valid flag, bit i belongs to lane i.
REQ-008 Port in_load, input, 1 bit: an input word set is offered this cycle.
REQ-009 Port in_ready, output, 1 bit: the block accepts an offered word set this cycle.
REQ-010 Port out_data, output, DATA_W bits: the serialized lane data.
REQ-011 Port out_vbit, output, 1 bit: the valid flag of the emitted lane.
REQ-012 Port out_lane, output, $clog2(NUM_LANES) bits: the index of the emitted lane.
REQ-013 Port out_valid, output, 1 bit: out_data, out_vbit and out_lane are meaningful this cycle.
REQ-014 Port out_ready, input, 1 bit: the sink consumes the current output this cycle.
REQ-015 Port overflow, output, 1 bit: sticky flag, set when in_load is high while in_ready is low.

Function
REQ-016 The block has two states: IDLE and SEND.
REQ-017 A word set is accepted on a rising edge where in_load=1 and in_ready=1.
REQ-018 Accepting a word set captures in_data and a pending-lane mask into holding registers.
REQ-019 Pending-lane mask: equal to in_lane_valid when SKIP_INVALID=1; all ones when SKIP_INVALID=0.
REQ-020 In IDLE: in_ready=1 and out_valid=0.
REQ-021 In IDLE, an accepted word set with a nonzero mask moves the block to SEND.
REQ-022 On that transition, the lane pointer is set to the lowest-index pending lane.
REQ-023 In IDLE, an accepted word set with an all-zero mask (possible only when SKIP_INVALID=1) is discarded and the block stays in IDLE.
REQ-024 Latency: out_valid=1 on the first cycle after the accepting edge; outputs are driven only from registers.
REQ-025 In SEND: out_valid=1, out_data = held data at the pointer lane, out_lane = pointer, out_vbit = held valid bit at the pointer lane.
REQ-026 In SEND, outputs hold stable while out_ready=0, for any number of cycles.
REQ-027 In SEND with out_ready=1: clear the pointer lane's mask bit and advance the pointer to the next higher-index pending lane.
REQ-028 The last word is the one where no higher-index pending lane remains.
REQ-029 In SEND, in_ready = (current word is the last word) AND out_ready; this is the only combinational input-to-output path.
REQ-030 When the last word is consumed with no accept in the same cycle, the block returns to IDLE.
REQ-031 When the last word is consumed and a word set is accepted in the same cycle, the new set is captured and the block stays in SEND with the pointer at its lowest pending lane, so there is no bubble cycle.
REQ-032 Exception to REQ-031: if that new set's mask is zero, it is discarded and the block goes to IDLE.
REQ-033 Sustained throughput is one lane word per cycle when out_ready=1 continuously.
REQ-034 Lane order is ascending index; the pointer never wraps within a word set.
REQ-035 in_load while in_ready=0 is ignored for data and sets overflow=1.
REQ-036 overflow clears only on reset.

Reset
REQ-037 While reset=1: state=IDLE, mask=0, pointer=0, held data=0, out_valid=0, out_data=0, out_vbit=0, out_lane=0, overflow=0, in_ready=1.
REQ-038 Assertion of reset in mid-operation aborts the current word set immediately; its remaining lanes are never emitted.
REQ-039 The first accept is possible on the first rising edge after reset deasserts.

Verification
REQ-040 Parameters 4/8/1; load 0x11,0x22,0x33,0x44 with valid=4'b1111; out_ready=1 -> 0x11,0x22,0x33,0x44 on lanes 0..3 in 4 consecutive cycles, starting 1 cycle after load.
REQ-041 SKIP_INVALID=1; valid=4'b1010; data 0xAA at lane 1, 0xBB at lane 3 -> exactly 2 outputs: (0xAA, lane 1), (0xBB, lane 3). Then valid=4'b0000 -> no output, stays in IDLE.
REQ-042 SKIP_INVALID=0; valid=4'b0101 -> 4 outputs with out_vbit = 1,0,1,0.
REQ-043 in_load held high with out_ready=1 -> back-to-back sets with no idle cycle; in_ready pulses only on last-lane cycles. Pulsing in_load while in_ready=0 -> overflow=1 sticky, stream uncorrupted.
REQ-044 out_ready=0 for 3 cycles during lane 2 -> outputs frozen on lane 2. Reset asserted during lane 2 -> out_valid=0 immediately; after release, a new set starts at its lowest pending lane.
REQ-045 Parameters NUM_LANES=8, DATA_W=16 with random masks and random out_ready -> a scoreboard matches every emitted word and lane index exactly.
